// File: rtl/gpio_sequence_monitor.sv
// gpio_sequence_monitor
// Watches a synchronized slice of the user IO bus and checks that it walks
// through a programmed list of masked values. Each value must be held for
// STABLE consecutive cycles and must be reached within a per-step timeout.
// Results are reported as sticky pass/fail flags, the failing step index and
// a one-cycle done pulse.
module gpio_sequence_monitor #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int STABLE    = 2,
  parameter int TIMEOUT_W = 16,
  localparam int SW       = $clog2(DEPTH + 1)
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   start,
  input  logic                   abort,
  input  logic [WIDTH-1:0]       io_in,
  input  logic [DEPTH*WIDTH-1:0] exp_value,
  input  logic [DEPTH*WIDTH-1:0] exp_mask,
  input  logic [SW-1:0]          num_steps,
  input  logic [TIMEOUT_W-1:0]   timeout,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic                   fail,
  output logic [SW-1:0]          step_idx,
  output logic [SW-1:0]          fail_step
);

  // The stable counter only ever needs to hold 0 .. STABLE-1.
  localparam int CW = (STABLE > 1) ? $clog2(STABLE) : 1;
  localparam logic [CW-1:0]        CNT_LAST  = CW'(STABLE - 1);
  localparam logic [SW-1:0]        MAX_STEPS = SW'(DEPTH);
  localparam logic [TIMEOUT_W-1:0] TIMER_SAT = '1;

  typedef enum logic {
    IDLE,
    CHECK
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0]       io_meta;
  logic [WIDTH-1:0]       io_s;
  logic [DEPTH*WIDTH-1:0] val_q, val_d;
  logic [DEPTH*WIDTH-1:0] mask_q, mask_d;
  logic [SW-1:0]          nsteps_q, nsteps_d;
  logic [SW-1:0]          num_clamped;
  logic [TIMEOUT_W-1:0]   tmo_q, tmo_d;
  logic [TIMEOUT_W-1:0]   timer_q, timer_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [SW-1:0]          step_d, fstep_d;
  logic                   done_d, pass_d, fail_d;
  logic [WIDTH-1:0]       cur_val, cur_mask;
  logic                   match;
  logic                   last_count;
  logic                   timed_out;

  assign busy        = (state_q == CHECK);
  assign num_clamped = (num_steps > MAX_STEPS) ? MAX_STEPS : num_steps;
  assign last_count  = (cnt_q == CNT_LAST);
  assign timed_out   = (tmo_q != '0) && (timer_q == tmo_q - TIMEOUT_W'(1));

  // Two-flop synchronizer: io_in is asynchronous to the wishbone clock.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      io_meta <= '0;
      io_s    <= '0;
    end else begin
      io_meta <= io_in;
      io_s    <= io_meta;
    end
  end

  // Select the latched value/mask pair for the step currently being checked.
  always_comb begin
    cur_val  = '0;
    cur_mask = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (step_idx == SW'(k)) begin
        cur_val  = val_q[k*WIDTH +: WIDTH];
        cur_mask = mask_q[k*WIDTH +: WIDTH];
      end
    end
    match = ((io_s ^ cur_val) & cur_mask) == '0;
  end

  // FSM state register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath decisions; abort beats acceptance beats timeout.
  always_comb begin
    state_d  = state_q;
    val_d    = val_q;
    mask_d   = mask_q;
    nsteps_d = nsteps_q;
    tmo_d    = tmo_q;
    timer_d  = timer_q;
    cnt_d    = cnt_q;
    step_d   = step_idx;
    fstep_d  = fail_step;
    done_d   = 1'b0;
    pass_d   = pass;
    fail_d   = fail;

    case (state_q)
      IDLE: begin
        if (start) begin
          val_d    = exp_value;
          mask_d   = exp_mask;
          nsteps_d = num_clamped;
          tmo_d    = timeout;
          step_d   = '0;
          cnt_d    = '0;
          timer_d  = '0;
          pass_d   = 1'b0;
          fail_d   = 1'b0;
          if (num_clamped == '0) begin
            pass_d = 1'b1;
            done_d = 1'b1;
          end else begin
            state_d = CHECK;
          end
        end
      end

      CHECK: begin
        if (abort) begin
          state_d = IDLE;
          fail_d  = 1'b1;
          fstep_d = step_idx;
          done_d  = 1'b1;
        end else if (match && last_count) begin
          step_d  = step_idx + SW'(1);
          cnt_d   = '0;
          timer_d = '0;
          if (step_d == nsteps_q) begin
            state_d = IDLE;
            pass_d  = 1'b1;
            done_d  = 1'b1;
          end
        end else if (timed_out) begin
          state_d = IDLE;
          fail_d  = 1'b1;
          fstep_d = step_idx;
          done_d  = 1'b1;
        end else begin
          timer_d = (timer_q == TIMER_SAT) ? timer_q : timer_q + TIMEOUT_W'(1);
          cnt_d   = match ? cnt_q + CW'(1) : '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Datapath and result registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      val_q     <= '0;
      mask_q    <= '0;
      nsteps_q  <= '0;
      tmo_q     <= '0;
      timer_q   <= '0;
      cnt_q     <= '0;
      step_idx  <= '0;
      fail_step <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
    end else begin
      val_q     <= val_d;
      mask_q    <= mask_d;
      nsteps_q  <= nsteps_d;
      tmo_q     <= tmo_d;
      timer_q   <= timer_d;
      cnt_q     <= cnt_d;
      step_idx  <= step_d;
      fail_step <= fstep_d;
      done      <= done_d;
      pass      <= pass_d;
      fail      <= fail_d;
    end
  end

endmodule

// File: tb/tb_gpio_sequence_monitor.sv
// Testbench for gpio_sequence_monitor: directed scenarios with fixed
// expectations plus randomized traffic compared against a behavioural model.
module tb_gpio_sequence_monitor;

  localparam int WIDTH     = 8;
  localparam int DEPTH     = 4;
  localparam int STABLE    = 2;
  localparam int TIMEOUT_W = 16;
  localparam int SW        = $clog2(DEPTH + 1);

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   start = 1'b0;
  logic                   abort = 1'b0;
  logic [WIDTH-1:0]       io_in = '0;
  logic [DEPTH*WIDTH-1:0] exp_value = '0;
  logic [DEPTH*WIDTH-1:0] exp_mask = '0;
  logic [SW-1:0]          num_steps = '0;
  logic [TIMEOUT_W-1:0]   timeout = '0;
  logic                   busy, done, pass, fail;
  logic [SW-1:0]          step_idx, fail_step;

  int vec_count = 0;
  int err_count = 0;

  // Reference model state.
  bit               m_busy, m_done, m_pass, m_fail, m_hit;
  int               m_step, m_fstep, m_run, m_elapsed, m_n, m_tmo;
  logic [WIDTH-1:0] m_val [DEPTH];
  logic [WIDTH-1:0] m_mask[DEPTH];
  logic [WIDTH-1:0] m_pipe[$];
  logic [WIDTH-1:0] m_seen;

  gpio_sequence_monitor #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .STABLE(STABLE), .TIMEOUT_W(TIMEOUT_W)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .abort(abort),
    .io_in(io_in), .exp_value(exp_value), .exp_mask(exp_mask),
    .num_steps(num_steps), .timeout(timeout), .busy(busy), .done(done),
    .pass(pass), .fail(fail), .step_idx(step_idx), .fail_step(fail_step)
  );

  always #5 clk = ~clk;

  // Behavioural model: the bus is seen two cycles late; each step needs
  // STABLE matching cycles in a row and fails once `timeout` cycles elapse.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_done = 0; m_pass = 0; m_fail = 0;
      m_step = 0; m_fstep = 0; m_run = 0; m_elapsed = 0;
      m_pipe = '{'0, '0};
    end else begin
      m_seen = m_pipe[0];
      m_done = 0;
      if (!m_busy) begin
        if (start) begin
          for (int k = 0; k < DEPTH; k++) begin
            m_val[k]  = exp_value[k*WIDTH +: WIDTH];
            m_mask[k] = exp_mask[k*WIDTH +: WIDTH];
          end
          m_n = (int'(num_steps) > DEPTH) ? DEPTH : int'(num_steps);
          m_tmo = int'(timeout);
          m_step = 0; m_run = 0; m_elapsed = 0; m_pass = 0; m_fail = 0;
          if (m_n == 0) begin
            m_pass = 1; m_done = 1;
          end else begin
            m_busy = 1;
          end
        end
      end else begin
        m_hit = (m_step < DEPTH) && (((m_seen ^ m_val[m_step]) & m_mask[m_step]) == '0);
        if (abort) begin
          m_busy = 0; m_fail = 1; m_fstep = m_step; m_done = 1;
        end else if (m_hit && m_run + 1 >= STABLE) begin
          m_step++; m_run = 0; m_elapsed = 0;
          if (m_step == m_n) begin
            m_busy = 0; m_pass = 1; m_done = 1;
          end
        end else if (m_tmo != 0 && m_elapsed + 1 >= m_tmo) begin
          m_busy = 0; m_fail = 1; m_fstep = m_step; m_done = 1;
        end else begin
          m_elapsed++;
          m_run = m_hit ? m_run + 1 : 0;
        end
      end
      void'(m_pipe.pop_front());
      m_pipe.push_back(io_in);
    end
  end

  // Single comparison point; every check is counted here.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    vec_count++;
    if (got !== want) begin
      err_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  task automatic compareOutputs();
    checkOutput("busy", busy, m_busy);
    checkOutput("done", done, m_done);
    checkOutput("pass", pass, m_pass);
    checkOutput("fail", fail, m_fail);
    checkOutput("step_idx", step_idx, m_step);
    if (m_fail) checkOutput("fail_step", fail_step, m_fstep);
  endtask

  // Drive one cycle of inputs, let the edge happen, then compare at negedge.
  task automatic applyStimulus(input logic [WIDTH-1:0] io, input logic st, input logic ab);
    io_in = io;
    start = st;
    abort = ab;
    @(posedge clk);
    @(negedge clk);
    compareOutputs();
  endtask

  task automatic setConfig(input logic [31:0] v, input logic [31:0] m, input int n, input int t);
    exp_value = v;
    exp_mask  = m;
    num_steps = SW'(n);
    timeout   = TIMEOUT_W'(t);
  endtask

  // Per-cycle io pattern for the directed scenarios (c = cycles after start).
  function automatic logic [WIDTH-1:0] ioFor(input int mode, input int c);
    case (mode)
      0: return (c > 10) ? 8'hFF : 8'h00;
      1: begin
        if (c == 0)  return 8'h00;
        if (c <= 5)  return 8'h01;
        if (c <= 10) return 8'h03;
        if (c <= 15) return 8'h07;
        return 8'h0F;
      end
      2: return 8'h03;
      4: return (c == 3) ? 8'hFF : 8'h00;
      5: return 8'hFF;
      default: return 8'h00;
    endcase
  endfunction

  // Run a directed check; dcyc is the cycle of done after start, -1 if none.
  task automatic runCheck(input int mode, input int abort_at, input int restart_at,
                          input int max_c, output int dcyc);
    for (int i = 0; i < 3; i++) applyStimulus(ioFor(mode, 0), 1'b0, 1'b0);
    applyStimulus(ioFor(mode, 0), 1'b1, 1'b0);
    dcyc = done ? 0 : -1;
    for (int c = 1; c <= max_c && dcyc < 0; c++) begin
      applyStimulus(ioFor(mode, c), c == restart_at, c == abort_at);
      if (mode == 1 && c % 5 == 0 && c <= 15) checkOutput("walk_step", step_idx, c / 5);
      if (done) dcyc = c;
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d;
    int done_seen;
    logic [WIDTH-1:0] io;

    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_pass", pass, 0);
    checkOutput("rst_fail", fail, 0);
    checkOutput("rst_step_idx", step_idx, 0);
    checkOutput("rst_fail_step", fail_step, 0);
    rst = 1'b0;

    $display("[TB] single step, io arrives 10 cycles after start");
    setConfig(32'hFF, 32'hFF, 1, 100);
    runCheck(0, -1, -1, 40, d);
    checkOutput("t1_done_cycle", d, 14);
    checkOutput("t1_pass", pass, 1);
    checkOutput("t1_fail", fail, 0);
    checkOutput("t1_step_idx", step_idx, 1);

    $display("[TB] four steps in order");
    setConfig(32'h0F070301, 32'hFFFFFFFF, 4, 50);
    runCheck(1, -1, -1, 40, d);
    checkOutput("seq_done_cycle", d, 19);
    checkOutput("seq_pass", pass, 1);
    checkOutput("seq_step_idx", step_idx, 4);

    $display("[TB] wrong first value");
    runCheck(2, -1, -1, 80, d);
    checkOutput("order_done_cycle", d, 50);
    checkOutput("order_fail", fail, 1);
    checkOutput("order_fail_step", fail_step, 0);
    checkOutput("order_pass", pass, 0);

    $display("[TB] timeout with bus held low");
    setConfig(32'hFF, 32'hFF, 1, 20);
    runCheck(3, -1, -1, 40, d);
    checkOutput("tmo_done_cycle", d, 20);
    checkOutput("tmo_fail", fail, 1);
    checkOutput("tmo_fail_step", fail_step, 0);

    $display("[TB] single-cycle glitch");
    runCheck(4, -1, -1, 40, d);
    checkOutput("glitch_done_cycle", d, 20);
    checkOutput("glitch_pass", pass, 0);

    $display("[TB] masked compare");
    setConfig(32'h80, 32'h80, 1, 100);
    runCheck(5, -1, -1, 40, d);
    checkOutput("mask_done_cycle", d, 2);
    checkOutput("mask_pass", pass, 1);

    $display("[TB] acceptance and timeout on the same edge");
    setConfig(32'hFF, 32'hFF, 1, 2);
    runCheck(5, -1, -1, 40, d);
    checkOutput("tie_done_cycle", d, 2);
    checkOutput("tie_pass", pass, 1);
    checkOutput("tie_fail", fail, 0);

    $display("[TB] zero steps");
    setConfig(32'hFF, 32'hFF, 0, 100);
    runCheck(3, -1, -1, 5, d);
    checkOutput("zero_done_cycle", d, 0);
    checkOutput("zero_pass", pass, 1);
    checkOutput("zero_busy", busy, 0);

    $display("[TB] num_steps clamps, start while busy ignored");
    setConfig(32'h0F070301, 32'hFFFFFFFF, 7, 50);
    runCheck(1, -1, 7, 40, d);
    checkOutput("clamp_done_cycle", d, 19);
    checkOutput("clamp_step_idx", step_idx, 4);
    checkOutput("clamp_pass", pass, 1);

    $display("[TB] abort during step 2");
    setConfig(32'h0F070301, 32'hFFFFFFFF, 4, 50);
    runCheck(1, 11, -1, 40, d);
    checkOutput("abort_done_cycle", d, 11);
    checkOutput("abort_fail", fail, 1);
    checkOutput("abort_fail_step", fail_step, 2);
    checkOutput("abort_pass", pass, 0);

    $display("[TB] asynchronous reset mid-check");
    for (int i = 0; i < 3; i++) applyStimulus(8'h00, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b1, 1'b0);
    for (int c = 1; c <= 5; c++) applyStimulus(ioFor(1, c), 1'b0, 1'b0);
    checkOutput("arst_pre_step", step_idx, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_done", done, 0);
    checkOutput("arst_pass", pass, 0);
    checkOutput("arst_fail", fail, 0);
    checkOutput("arst_step_idx", step_idx, 0);
    checkOutput("arst_fail_step", fail_step, 0);
    @(negedge clk);
    rst = 1'b0;
    compareOutputs();
    runCheck(1, -1, -1, 40, d);
    checkOutput("arst_rerun_done_cycle", d, 19);
    checkOutput("arst_rerun_pass", pass, 1);

    $display("[TB] timeout disabled, long run");
    setConfig(32'hFF, 32'hFF, 1, 0);
    runCheck(3, -1, -1, 70000, d);
    checkOutput("notmo_done_cycle", d, -1);
    checkOutput("notmo_busy", busy, 1);
    applyStimulus(8'h00, 1'b0, 1'b1);
    checkOutput("notmo_abort_fail", fail, 1);

    $display("[TB] randomized checks");
    for (int t = 0; t < 40; t++) begin
      logic [31:0] v, m;
      v = $urandom;
      for (int k = 0; k < DEPTH; k++) begin
        case ($urandom_range(0, 7))
          0:       m[k*WIDTH +: WIDTH] = 8'h00;
          1, 2, 3: m[k*WIDTH +: WIDTH] = 8'hFF;
          default: m[k*WIDTH +: WIDTH] = WIDTH'($urandom);
        endcase
      end
      setConfig(v, m, $urandom_range(0, 7),
                ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(3, 40));
      applyStimulus(WIDTH'($urandom), 1'b1, 1'b0);
      done_seen = 0;
      while (m_busy && done_seen < 300) begin
        if ($urandom_range(0, 9) < 7 && m_step < DEPTH)
          io = (m_val[m_step] & m_mask[m_step]) | (WIDTH'($urandom) & ~m_mask[m_step]);
        else
          io = WIDTH'($urandom);
        for (int h = $urandom_range(1, 6); h > 0; h--) begin
          applyStimulus(io, $urandom_range(0, 29) == 0, $urandom_range(0, 199) == 0);
          done_seen++;
        end
      end
      if (m_busy) applyStimulus(io, 1'b0, 1'b1);
      applyStimulus(WIDTH'($urandom), 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
